// File: rtl/ts_injection_slot_scheduler_pkg.sv
// ts_injection_slot_scheduler_pkg: shared FSM encodings, table entry fields and config constants
package ts_injection_slot_scheduler_pkg;
  typedef enum logic [2:0] {
    ISM_IDLE  = 3'd0,
    ISM_WAIT  = 3'd1,
    ISM_RD    = 3'd2,
    ISM_EVAL  = 3'd3,
    ISM_ISSUE = 3'd4
  } ism_state_t;
  localparam int VALID_BIT = 15;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 4;
  localparam logic [1:0] CFG_DONE = 2'b11;
  function automatic logic [10:0] clamp_period(input logic [10:0] p);
    return p == 11'd0 ? 11'd1 : (p > 11'd1024 ? 11'd1024 : p);
  endfunction
endpackage

// File: rtl/injection_slot_table_ram.sv
// injection_slot_table_ram: simple dual-port RAM, port A write/read and port B read, 1-cycle read, read-old on collision
module injection_slot_table_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic          a_re,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_re,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (a_re) a_rdata <= mem[a_addr];
  end
  always_ff @(posedge clk) begin
    if (b_re) b_rdata <= mem[b_addr];
  end
endmodule

// File: rtl/ts_injection_slot_scheduler.sv
// ts_injection_slot_scheduler: slot counter from global time, per-slot table lookup and wr/ack handoff of the TS flow address
module ts_injection_slot_scheduler
  import ts_injection_slot_scheduler_pkg::*;
#(
  parameter int SLOT_W = 10,
  parameter int TBL_DW = 16,
  parameter int INJ_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        iv_cfg_finish,
  input  logic              i_timer_rst,
  input  logic [47:0]       iv_syned_global_time,
  input  logic [10:0]       iv_time_slot_length,
  input  logic [10:0]       iv_time_slot_period,
  output logic [SLOT_W-1:0] ov_time_slot,
  output logic              o_time_slot_switch,
  output logic [INJ_AW-1:0] ov_ts_injection_addr,
  output logic              o_ts_injection_addr_wr,
  input  logic              i_ts_injection_addr_ack,
  input  logic [TBL_DW-1:0] iv_injection_slot_table_wdata,
  input  logic              i_injection_slot_table_wr,
  input  logic [SLOT_W-1:0] iv_injection_slot_table_addr,
  input  logic              i_injection_slot_table_rd,
  output logic [TBL_DW-1:0] ov_injection_slot_table_rdata,
  output logic              o_injection_slot_table_rd_valid,
  output logic              o_injection_miss_pulse,
  output logic [2:0]        ism_state
);
  logic t10_q, tick, active, last_us, last_slot, rd_d1, wr_n, miss_n, rd_b, unused_bits;
  logic [10:0] len_e, per_e, us_cnt;
  logic [TBL_DW-1:0] q_a, q_b;
  logic [INJ_AW-1:0] addr_n;
  ism_state_t state, state_n;
  assign tick = iv_syned_global_time[10] ^ t10_q;
  assign active = iv_cfg_finish == CFG_DONE && !i_timer_rst;
  assign len_e = iv_time_slot_length == 11'd0 ? 11'd1 : iv_time_slot_length;
  assign per_e = clamp_period(iv_time_slot_period);
  assign last_us = us_cnt == len_e - 11'd1;
  assign last_slot = 11'(ov_time_slot) == per_e - 11'd1;
  assign ism_state = state;
  assign unused_bits = ^{iv_syned_global_time[47:11], iv_syned_global_time[9:0], q_b[VALID_BIT-1:ADDR_MSB+1]};
  always_ff @(posedge i_clk) begin
    t10_q <= i_rst ? 1'b0 : iv_syned_global_time[10];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || !active) begin
      us_cnt             <= '0;
      ov_time_slot       <= '0;
      o_time_slot_switch <= 1'b0;
    end else begin
      o_time_slot_switch <= tick && last_us;
      if (tick) begin
        us_cnt <= last_us ? '0 : us_cnt + 11'd1;
        if (last_us) ov_time_slot <= last_slot ? '0 : ov_time_slot + SLOT_W'(1);
      end
    end
  end
  always_comb begin
    state_n = state;
    wr_n    = o_ts_injection_addr_wr;
    addr_n  = ov_ts_injection_addr;
    miss_n  = 1'b0;
    rd_b    = 1'b0;
    if (!active) begin
      state_n = ISM_IDLE;
      wr_n    = 1'b0;
    end else if (state == ISM_IDLE) begin
      state_n = ISM_WAIT;
    end else if (o_time_slot_switch) begin
      state_n = ISM_RD;
      rd_b    = 1'b1;
      wr_n    = 1'b0;
      miss_n  = state == ISM_ISSUE && !i_ts_injection_addr_ack;
    end else if (state == ISM_RD) begin
      state_n = ISM_EVAL;
    end else if (state == ISM_EVAL) begin
      state_n = q_b[VALID_BIT] ? ISM_ISSUE : ISM_WAIT;
      wr_n    = q_b[VALID_BIT];
      addr_n  = q_b[VALID_BIT] ? INJ_AW'(q_b[ADDR_MSB:ADDR_LSB]) : ov_ts_injection_addr;
    end else if (state == ISM_ISSUE && i_ts_injection_addr_ack) begin
      state_n = ISM_WAIT;
      wr_n    = 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                  <= ISM_IDLE;
      o_ts_injection_addr_wr <= 1'b0;
      ov_ts_injection_addr   <= '0;
      o_injection_miss_pulse <= 1'b0;
    end else begin
      state                  <= state_n;
      o_ts_injection_addr_wr <= wr_n;
      ov_ts_injection_addr   <= addr_n;
      o_injection_miss_pulse <= miss_n;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_d1                           <= 1'b0;
      o_injection_slot_table_rd_valid <= 1'b0;
      ov_injection_slot_table_rdata   <= '0;
    end else begin
      rd_d1                           <= i_injection_slot_table_rd;
      o_injection_slot_table_rd_valid <= rd_d1;
      if (rd_d1) ov_injection_slot_table_rdata <= q_a;
    end
  end
  injection_slot_table_ram #(.AW(SLOT_W), .DW(TBL_DW)) u_ram (
    .clk     (i_clk),
    .a_we    (i_injection_slot_table_wr),
    .a_re    (i_injection_slot_table_rd),
    .a_addr  (iv_injection_slot_table_addr),
    .a_wdata (iv_injection_slot_table_wdata),
    .a_rdata (q_a),
    .b_re    (rd_b),
    .b_addr  (ov_time_slot),
    .b_rdata (q_b)
  );
endmodule

// File: doc/ts_injection_slot_scheduler.md
Name: ts_injection_slot_scheduler

Overview:
- Time-slot scheduler for the host receive path; generates the injection time slot from synchronized global time.
- Looks up a 1024-entry injection slot table each slot and hands the scheduled TS flow address to the TS injection management stage over a wr/ack handshake.
- Sits between the time-sync logic and TS descriptor injection; the table is configured through the register interface.

Parameters:
SLOT_W, 10, width of time-slot index and table address (table depth 2^SLOT_W)
TBL_DW, 16, injection slot table entry width
INJ_AW, 5, width of injected TS flow address (32 TS flows)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
iv_cfg_finish  in  2  scheduling enabled only when 2'b11
i_timer_rst  in  1  one-cycle pulse: resync slot counter
iv_syned_global_time  in  48  synchronized global time, ns
iv_time_slot_length  in  11  slot length in us (1 us = 1024 ns); 0 treated as 1
iv_time_slot_period  in  11  table period in slots; 0 treated as 1, values >1024 clamp to 1024
ov_time_slot  out  SLOT_W  current slot index
o_time_slot_switch  out  1  one-cycle pulse on slot change
ov_ts_injection_addr  out  INJ_AW  scheduled TS flow address
o_ts_injection_addr_wr  out  1  address valid, held until ack
i_ts_injection_addr_ack  in  1  consumer accepted address
iv_injection_slot_table_wdata  in  TBL_DW  config write data
i_injection_slot_table_wr  in  1  config write strobe
iv_injection_slot_table_addr  in  SLOT_W  config address
i_injection_slot_table_rd  in  1  config read strobe
ov_injection_slot_table_rdata  out  TBL_DW  config read data
o_injection_slot_table_rd_valid  out  1  rdata valid pulse
o_injection_miss_pulse  out  1  pending injection dropped by next slot
ism_state  out  3  FSM state for debug

Behaviour:
- All outputs reset to 0; FSM to IDLE; table contents not reset (config rewrites after reset).
- Microsecond tick: register global_time[10]; tick = any change of bit 10 vs previous cycle.
- Slot counter: us_cnt counts ticks; when us_cnt == len-1 and tick: us_cnt<=0, slot<=(slot==period-1)?0:slot+1, o_time_slot_switch=1 next cycle.
- i_timer_rst, or iv_cfg_finish!=2'b11: us_cnt<=0, slot<=0, no switch pulses, FSM->IDLE, wr deasserted, no miss pulse.
- Table: simple dual-port 2^SLOT_W x TBL_DW; port A config write/read, port B scheduler read; read latency 1 cycle each.
- Config read: rdata registered; rd_valid pulses 2 cycles after rd strobe. Simultaneous wr and rd to same address returns old data. Config access allowed at any time.
- Entry format: [15] valid, [14:5] reserved (ignored), [4:0] injection address.
- FSM: IDLE(0): enter WAIT(1) when cfg_finish==2'b11.
- WAIT: on slot switch -> RD(2), issue port-B read at new slot.
- RD: one cycle -> EVAL(3).
- EVAL: entry valid -> drive addr, wr=1, ISSUE(4); else -> WAIT.
- ISSUE: ack -> wr=0, WAIT. Ack and slot switch in same cycle: ack wins, then go straight to RD for the new slot, no miss.
- ISSUE, slot switch without ack: wr=0, o_injection_miss_pulse=1 for one cycle, go to RD.
- Ack outside ISSUE is ignored.
- Latency: slot switch pulse to wr assertion = 3 cycles.
- Slot pulse arriving in RD/EVAL (length=1 us, still >=1024 cycles) is impossible; if seen, restart at RD without a miss pulse.
- ov_time_slot updates in the same cycle as the switch pulse.

Decomposition:
- Shared package: FSM state encodings (IDLE..ISSUE), entry field positions (VALID_BIT=15, ADDR_LSB/MSB), CFG_DONE=2'b11.
- One sub-module, injection_slot_table_ram: generic simple dual-port RAM, 1-cycle read.

Test Plan:
1. Write slot 3 = 16'h8005, length=1, period=8, cfg=11; advance time -> at slot 3, wr=1 with addr=5 three cycles after switch; ack clears wr, FSM back to WAIT.
2. Entry 16'h0007 (valid=0) at slot 2 -> no wr; ism_state passes RD, EVAL, WAIT.
3. Withhold ack across switch to slot 4 (16'h8009) -> miss pulse once, then wr with addr=9.
4. Period=4 -> slot sequence 0,1,2,3,0. Pulse i_timer_rst at slot 2 -> slot=0, us_cnt=0.
5. Config: write addr 10 = 16'hABCD, rd addr 10 -> rd_valid 2 cycles later with rdata=16'hABCD. Same-cycle wr/rd to same address returns old data.
6. Drop cfg_finish to 01 mid-ISSUE -> wr=0 next cycle, slot=0, no miss pulse. Assert i_rst mid-ISSUE -> all outputs 0.
